simd_ram_arbiter: RTL
=====================

# simd_ram_arbiter

Two-requester arbiter for the single-port 256-bit vector data RAM. It shares the port between the SIMD processor's memory stage and a host/loader port (program load, result readback, DMA). The processor has priority and sees a same-cycle stall when it loses; the host uses a req/gnt handshake. An optional starvation guard bounds host wait time. It sits between `simd_processor`'s `*_RAM` pins and the RAM macro.

## Interface
- `RD_LATENCY`, 1: RAM read latency in cycles (1..3).
- `HOST_MAX_WAIT`, 8: consecutive denied host-request cycles before a forced host grant (2..255). Used only with the guard enabled.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `p_address` in 14: processor word address.
- `p_byteena` in 32: processor byte enables.
- `p_wdata` in 256: processor write data.
- `p_rden`, `p_wren` in 1: processor read/write request.
- `p_stall` out 1: processor request not serviced this cycle.
- `p_rdata` out 256: read data.
- `p_rvalid` out 1: `p_rdata` valid.
- `h_req` in 1: host request.
- `h_we` in 1: host write (1) / read (0).
- `h_address` in 14, `h_byteena` in 32, `h_wdata` in 256: host transaction.
- `h_gnt` out 1: host request accepted this cycle.
- `h_rdata` out 256, `h_rvalid` out 1: host read return.
- `ram_address` out 14, `ram_byteena` out 32, `ram_wdata` out 256, `ram_rden` out 1, `ram_wren` out 1: RAM port.
- `ram_rdata` in 256: RAM read data.
- `stall_count` out 32: saturating count of cycles with `p_stall`=1.

## Operation
- Request definitions: P request = `p_rden|p_wren`. If both are set, treat it as a write and suppress `ram_rden`. H request = `h_req`.
- Winner selection is combinational each cycle:
  - Only P requests: P wins.
  - Only H requests: H wins.
  - Both request: P wins, unless FSM state is FORCE (then H wins).
  - Neither: RAM port idle, `ram_rden`=`ram_wren`=0.
- RAM mux: winner's address/byteena/wdata drive the RAM. When idle, these outputs hold P's values.
- `p_stall` = P request & H wins. `h_gnt` = `h_req` & H wins.
- Host handshake: host holds `h_req` and all `h_*` stable until it samples `h_gnt`=1. The transaction is accepted in that cycle. The host may drop `h_req` without penalty.
- Read return: an accepted read pushes an owner tag (P/H) into an `RD_LATENCY`-deep shift register. At the tap, raise `p_rvalid` or `h_rvalid` for exactly one cycle. `p_rdata` = `h_rdata` = `ram_rdata`, qualified only by the rvalid flags.
- FSM (guard enabled):
  - NORMAL: `wait_cnt` increments on each cycle with `h_req` & !`h_gnt`. It clears on `h_gnt`, or when `h_req`=0.
  - NORMAL→FORCE at the clock edge where `wait_cnt` reaches `HOST_MAX_WAIT`.
  - FORCE→NORMAL on the first `h_gnt`, or on a cycle with `h_req`=0. `wait_cnt` clears on entry to NORMAL.
- `stall_count` increments each `p_stall` cycle and saturates at 0xFFFF_FFFF.

## Timing
- RAM-port outputs, `p_stall`, `h_gnt`: combinational, same cycle as the request.
- Read data: rvalid asserted `RD_LATENCY` cycles after acceptance. Back-to-back reads from either requester are sustained at 1/cycle with no bubbles. A write and a read in consecutive cycles have no hazard handling; the RAM order governs.
- Reset (`reset`=0, async):
  - Tag pipe cleared; in-flight reads are dropped with no rvalid.
  - FSM=NORMAL, `wait_cnt`=0, `stall_count`=0.
  - `h_gnt`, `p_stall`, `p_rvalid`, `h_rvalid`, `ram_rden`, `ram_wren` forced 0.
  - Address/data outputs 0.
- Reset release: arbitration resumes on the first rising edge with `reset`=1.
- Simultaneous FORCE exit and new `h_req` collision: the state updates first, so the next cycle is NORMAL (P priority).
- In FORCE with no P request, H wins normally, and the exit is the same.

## Configuration
- `SIMD_ARB_STARVE_GUARD_EN` defined: FSM and `wait_cnt` present. Worst-case host wait is `HOST_MAX_WAIT`+1 cycles.
- Undefined: no FSM; strict processor priority. The host may starve indefinitely. `HOST_MAX_WAIT` is ignored.

## Test plan
- P read at addr 0x0010 alone, `RD_LATENCY`=1 → `ram_rden`=1, `ram_address`=0x0010 same cycle; `p_rvalid`=1 one cycle later with `ram_rdata`; `p_stall`=0.
- H write to 0x0200, P idle → `h_gnt`=1 same cycle, `ram_wren`=1 with `h_byteena`/`h_wdata`; no rvalid.
- P and H both request for 3 cycles, guard off → `p_stall`=0, `h_gnt`=0 all 3 cycles; H granted in the first cycle P idles; `stall_count`=0.
- Guard on, `HOST_MAX_WAIT`=4, P and H request continuously → `h_gnt` on cycle 5 with `p_stall`=1 that cycle; `stall_count`=1; then P wins again; repeats every 5 cycles.
- Interleaved reads P,H,P with `RD_LATENCY`=2 → `p_rvalid`, `h_rvalid`, `p_rvalid` on cycles 3,4,5, each one cycle.
- `reset` asserted with 2 reads in flight → no rvalid ever appears for them; `stall_count`=0; `h_gnt`=0 while reset low.

Source files
------------

// File: rtl/simd_ram_arbiter.sv
// simd_ram_arbiter: shares the single-port 256-bit vector data RAM between the
// SIMD processor memory stage (priority, same-cycle stall) and a host/loader
// port (req/gnt handshake). Read returns are steered by an owner-tag pipe.
// Optional host starvation guard: define SIMD_ARB_STARVE_GUARD_EN.
module simd_ram_arbiter #(
   parameter int unsigned RD_LATENCY    = 1,
   parameter int unsigned HOST_MAX_WAIT = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [13:0]  p_address,
   input  logic [31:0]  p_byteena,
   input  logic [255:0] p_wdata,
   input  logic         p_rden,
   input  logic         p_wren,
   output logic         p_stall,
   output logic [255:0] p_rdata,
   output logic         p_rvalid,
   input  logic         h_req,
   input  logic         h_we,
   input  logic [13:0]  h_address,
   input  logic [31:0]  h_byteena,
   input  logic [255:0] h_wdata,
   output logic         h_gnt,
   output logic [255:0] h_rdata,
   output logic         h_rvalid,
   output logic [13:0]  ram_address,
   output logic [31:0]  ram_byteena,
   output logic [255:0] ram_wdata,
   output logic         ram_rden,
   output logic         ram_wren,
   input  logic [255:0] ram_rdata,
   output logic [31:0]  stall_count
);

   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_lat_chk
      $error("simd_ram_arbiter: RD_LATENCY out of range 1..3");
   end
   if (HOST_MAX_WAIT < 2 || HOST_MAX_WAIT > 255) begin : g_wait_chk
      $error("simd_ram_arbiter: HOST_MAX_WAIT out of range 2..255");
   end

   logic p_req;
   logic h_force;
   logic h_win;
   logic p_win;
   logic p_rd_acc;
   logic h_rd_acc;
   logic [RD_LATENCY-1:0] p_tag;
   logic [RD_LATENCY-1:0] h_tag;

   // Winner selection and RAM port mux; everything held low while in reset
   always_comb begin
      p_req       = p_rden | p_wren;
      h_win       = h_req & (~p_req | h_force);
      p_win       = p_req & ~h_win;
      p_stall     = reset & p_req & h_win;
      h_gnt       = reset & h_win;
      ram_rden    = 1'b0;
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_byteena = '0;
      ram_wdata   = '0;
      if (reset) begin
         if (h_win) begin
            ram_rden    = ~h_we;
            ram_wren    = h_we;
            ram_address = h_address;
            ram_byteena = h_byteena;
            ram_wdata   = h_wdata;
         end else begin
            // P values also drive the port when idle; a read+write is a write
            ram_rden    = p_win & p_rden & ~p_wren;
            ram_wren    = p_win & p_wren;
            ram_address = p_address;
            ram_byteena = p_byteena;
            ram_wdata   = p_wdata;
         end
      end
      p_rd_acc = ram_rden & p_win;
      h_rd_acc = ram_rden & h_win;
   end

   // Owner-tag shift register; the tap marks which requester gets ram_rdata
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_tag <= '0;
         h_tag <= '0;
      end else begin
         p_tag[0] <= p_rd_acc;
         h_tag[0] <= h_rd_acc;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            p_tag[i] <= p_tag[i-1];
            h_tag[i] <= h_tag[i-1];
         end
      end
   end

   // Read data is shared; only the valid flags distinguish the owner
   always_comb begin
      p_rvalid = p_tag[RD_LATENCY-1];
      h_rvalid = h_tag[RD_LATENCY-1];
      p_rdata  = reset ? ram_rdata : '0;
      h_rdata  = reset ? ram_rdata : '0;
   end

   // Saturating count of processor stall cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (p_stall && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end

`ifdef SIMD_ARB_STARVE_GUARD_EN
   typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;

   // Guard state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_NORMAL;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Count denied host cycles; force one host grant once the limit is hit
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         ST_NORMAL: begin
            if (h_req && !h_gnt) begin
               wait_nxt = wait_cnt + 8'd1;
               if (wait_nxt == HOST_MAX_WAIT[7:0]) state_nxt = ST_FORCE;
            end else begin
               wait_nxt = '0;
            end
         end
         ST_FORCE: begin
            if (!h_req || h_gnt) begin
               state_nxt = ST_NORMAL;
               wait_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_NORMAL;
            wait_nxt  = '0;
         end
      endcase
   end

   assign h_force = (state == ST_FORCE);
`else
   assign h_force = 1'b0;
`endif

endmodule
